// File: rtl/gpio_core_pkg.sv
// Shared definitions for the GPIO core controller: register map,
// register-port handshake states and synchroniser depth floor.
package gpio_core_pkg;

  localparam logic [2:0] ADDR_DOUT  = 3'd0;
  localparam logic [2:0] ADDR_DIR   = 3'd1;
  localparam logic [2:0] ADDR_DIN   = 3'd2;
  localparam logic [2:0] ADDR_IEN   = 3'd3;
  localparam logic [2:0] ADDR_ISTAT = 3'd4;
  localparam logic [2:0] ADDR_ESEL  = 3'd5;
  localparam logic [2:0] ADDR_EBOTH = 3'd6;

  localparam int MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/gpio_sync_deb.sv
// Single-pin pad input conditioner: synchroniser chain, plus a stability
// filter when GPIO_DEBOUNCE_EN is defined.
module gpio_sync_deb
  import gpio_core_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Depths below the floor would defeat metastability protection.
  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] chain;
  logic              sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign sync = chain[STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int               CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             deb;

  // cnt counts consecutive cycles of disagreement; the last one flips deb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync == deb) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
      deb <= sync;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign q = deb;
`else
  logic unused_deb_cfg;
  assign unused_deb_cfg = (DEB_CYCLES > 0);
  assign q = sync;
`endif

endmodule

// File: rtl/gpio_core_ctrl.sv
// GPIO pad-ring core controller: register port, pad drive, input edge IRQs.
// Optional per-pin debounce is enabled by defining GPIO_DEBOUNCE_EN.
//
// state  | meaning
// IDLE   | waiting for reg_valid
// ACCEPT | reg_ready high; write commits / read data captured at this edge
// RESP   | reg_rvalid high for the captured read data
module gpio_core_ctrl
  import gpio_core_pkg::*;
#(
  parameter int GPIO_WIDTH  = 15,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_valid,
  output logic                  reg_ready,
  input  logic                  reg_write,
  input  logic [2:0]            reg_addr,
  input  logic [GPIO_WIDTH-1:0] reg_wdata,
  output logic [GPIO_WIDTH-1:0] reg_rdata,
  output logic                  reg_rvalid,
  input  logic [GPIO_WIDTH-1:0] pad_in,
  output logic [GPIO_WIDTH-1:0] pad_out,
  output logic [GPIO_WIDTH-1:0] pad_oe,
  output logic                  irq
);

  state_t state, state_next;

  logic [GPIO_WIDTH-1:0] dout, dir, ien, istat, esel, eboth;
  logic [GPIO_WIDTH-1:0] din, prev, rise, fall, edge_mask, clr_mask, rd_mux;
  logic                  wr_en, rd_en, irq_q;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    gpio_sync_deb #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_sync_deb (
      .clk(clk),
      .rst(rst),
      .d  (pad_in[i]),
      .q  (din[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    reg_ready  = 1'b0;
    reg_rvalid = 1'b0;
    case (state)
      IDLE:    if (reg_valid) state_next = ACCEPT;
      ACCEPT: begin
        reg_ready  = 1'b1;
        state_next = reg_write ? IDLE : RESP;
      end
      RESP: begin
        reg_rvalid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_en = reg_ready & reg_write;
  assign rd_en = reg_ready & ~reg_write;

  assign rise      = din & ~prev;
  assign fall      = ~din & prev;
  assign edge_mask = (eboth & (rise | fall)) | (~eboth & ((esel & rise) | (~esel & fall)));
  assign clr_mask  = (wr_en && reg_addr == ADDR_ISTAT) ? reg_wdata : '0;

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_DOUT:  rd_mux = dout;
      ADDR_DIR:   rd_mux = dir;
      ADDR_DIN:   rd_mux = din;
      ADDR_IEN:   rd_mux = ien;
      ADDR_ISTAT: rd_mux = istat;
      ADDR_ESEL:  rd_mux = esel;
      ADDR_EBOTH: rd_mux = eboth;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= '0;
      dir       <= '0;
      ien       <= '0;
      istat     <= '0;
      esel      <= '0;
      eboth     <= '0;
      prev      <= '0;
      irq_q     <= 1'b0;
      reg_rdata <= '0;
    end else begin
      if (wr_en) begin
        case (reg_addr)
          ADDR_DOUT:  dout  <= reg_wdata;
          ADDR_DIR:   dir   <= reg_wdata;
          ADDR_IEN:   ien   <= reg_wdata;
          ADDR_ESEL:  esel  <= reg_wdata;
          ADDR_EBOTH: eboth <= reg_wdata;
          default: ;
        endcase
      end
      // Edge set takes priority over a simultaneous W1C of the same bit.
      istat <= (istat & ~clr_mask) | edge_mask;
      prev  <= din;
      irq_q <= |(istat & ien);
      if (rd_en) reg_rdata <= rd_mux;
    end
  end

  assign pad_out = dout;
  assign pad_oe  = dir;
  assign irq     = irq_q;

endmodule
